// File: rtl/axis_pkg.sv
// axis_pkg: shared beat type, widths and frame-state enum for the AXI-Stream receive stage
package axis_pkg;
  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_STRB_W = 4;
  localparam int AXIS_USER_W = 2;
  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_STRB_W-1:0] tstrb;
    logic [AXIS_STRB_W-1:0] tkeep;
    logic                   tlast;
    logic [AXIS_USER_W-1:0] tuser;
  } axis_beat_t;
  typedef enum logic {S_IDLE, S_FRAME} frame_state_t;
  function automatic logic is_null(input axis_beat_t b);
    return b.tkeep == '0 && !b.tlast;
  endfunction
endpackage

// File: rtl/axis_rx_fifo.sv
// axis_rx_fifo: synchronous beat FIFO (wr_vld/wr_rdy in, rd_vld/rd_rdy/rd_data out, zero data when empty)
module axis_rx_fifo import axis_pkg::*; #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_vld,
  output logic       wr_rdy,
  input  axis_beat_t wr_data,
  output logic       rd_vld,
  input  logic       rd_rdy,
  output axis_beat_t rd_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  axis_beat_t mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr, rd;
  always_comb begin
    wr_rdy = cnt_q < (AW+1)'(FIFO_DEPTH);
    rd_vld = cnt_q != '0;
    wr = wr_vld && wr_rdy;
    rd = rd_vld && rd_rdy;
    rd_data = rd_vld ? mem_q[rd_ptr_q] : '0;
    wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d = (wr && !rd) ? cnt_q + 1'b1 : (rd && !wr) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/axis_slave.sv
// axis_slave: AXI-Stream receive stage (axis_* in, buffered bk_* valid/ready out, frame_done/beat_cnt/nordy status)
module axis_slave import axis_pkg::*; #(
  parameter int FIFO_DEPTH = 8,
  parameter int BK_RDY_TIMEOUT = 5,
  parameter int CNT_W = 8
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  input  logic                   axis_tvalid,
  input  logic [AXIS_DATA_W-1:0] axis_tdata,
  input  logic [AXIS_STRB_W-1:0] axis_tstrb,
  input  logic [AXIS_STRB_W-1:0] axis_tkeep,
  input  logic                   axis_tlast,
  input  logic [AXIS_USER_W-1:0] axis_tuser,
  output logic                   axis_tready,
  output logic                   bk_valid,
  output logic [AXIS_DATA_W-1:0] bk_data,
  output logic [AXIS_STRB_W-1:0] bk_tstrb,
  output logic [AXIS_STRB_W-1:0] bk_tkeep,
  output logic [AXIS_USER_W-1:0] bk_user,
  output logic                   bk_last,
  input  logic                   bk_ready,
  output logic                   bk_frame_done,
  output logic [CNT_W-1:0]       bk_beat_cnt,
  output logic                   bk_nordy
);
  localparam int SW = $clog2(BK_RDY_TIMEOUT + 1);
  axis_beat_t in_beat, head;
  frame_state_t state_q, state_d;
  logic run_q, fifo_rdy, rd, complete, done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, beat_cnt_q, beat_cnt_d;
  logic [SW-1:0] stall_q, stall_d;
  assign in_beat = '{axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tuser};
  axis_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(axi_aclk),
    .rst_n(axi_aresetn),
    .wr_vld(axis_tvalid && run_q && !is_null(in_beat)),
    .wr_rdy(fifo_rdy),
    .wr_data(in_beat),
    .rd_vld(bk_valid),
    .rd_rdy(bk_ready),
    .rd_data(head)
  );
  always_comb begin
    axis_tready = run_q && fifo_rdy;
    bk_data = head.tdata;
    bk_tstrb = head.tstrb;
    bk_tkeep = head.tkeep;
    bk_user = head.tuser;
    bk_last = head.tlast;
    bk_frame_done = done_q;
    bk_beat_cnt = beat_cnt_q;
    bk_nordy = stall_q >= SW'(BK_RDY_TIMEOUT);
    rd = bk_valid && bk_ready;
    complete = rd && bk_last;
    cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
    state_d = rd ? (bk_last ? S_IDLE : S_FRAME) : state_q;
    cnt_d = complete ? '0 : rd ? cnt_inc : cnt_q;
    done_d = complete;
    beat_cnt_d = complete ? cnt_inc : beat_cnt_q;
    stall_d = (!bk_valid || rd) ? '0 : bk_nordy ? stall_q : stall_q + 1'b1;
  end
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      run_q <= 1'b0;
      state_q <= S_IDLE;
      cnt_q <= '0;
      done_q <= 1'b0;
      beat_cnt_q <= '0;
      stall_q <= '0;
    end else begin
      run_q <= 1'b1;
      state_q <= state_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      beat_cnt_q <= beat_cnt_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_axis_slave.sv
// tb_axis_slave: directed self-checking bench for axis_slave
module tb_axis_slave;
  logic clk = 1'b0, rst_n = 1'b0;
  logic tvalid = 1'b0, tlast = 1'b0, tready, bk_valid, bk_last, bk_ready = 1'b0, frame_done, nordy;
  logic [31:0] tdata = '0, bk_data;
  logic [3:0] tstrb = '0, tkeep = '0, bk_tstrb, bk_tkeep;
  logic [1:0] tuser = '0, bk_user;
  logic [7:0] beat_cnt;
  int n_checks = 0, n_pass = 0;
  always #5 clk = ~clk;
  axis_slave dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .axis_tvalid(tvalid), .axis_tdata(tdata), .axis_tstrb(tstrb), .axis_tkeep(tkeep),
    .axis_tlast(tlast), .axis_tuser(tuser), .axis_tready(tready),
    .bk_valid(bk_valid), .bk_data(bk_data), .bk_tstrb(bk_tstrb), .bk_tkeep(bk_tkeep),
    .bk_user(bk_user), .bk_last(bk_last), .bk_ready(bk_ready),
    .bk_frame_done(frame_done), .bk_beat_cnt(beat_cnt), .bk_nordy(nordy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l);
    tvalid = 1'b1;
    tdata = d;
    tstrb = k;
    tkeep = k;
    tlast = l;
    tuser = d[1:0];
  endtask
  task automatic idle();
    tvalid = 1'b0;
    tdata = '0;
    tkeep = '0;
    tstrb = '0;
    tlast = 1'b0;
    tuser = '0;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_tready"}, tready, 0);
    check({tag, "_valid"}, bk_valid, 0);
    check({tag, "_fields"}, {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last}, 0);
    check({tag, "_done"}, frame_done, 0);
    check({tag, "_cnt"}, beat_cnt, 0);
    check({tag, "_nordy"}, nordy, 0);
  endtask
  initial begin
    step();
    step();
    check_zero("rst");
    rst_n = 1'b1;
    step();
    check("rst_tready_up", tready, 1);
    // single-beat frame
    bk_ready = 1'b1;
    drive(32'hA5A5_0001, 4'hF, 1'b1);
    step();
    idle();
    check("t1_valid", bk_valid, 1);
    check("t1_data", bk_data, 32'hA5A5_0001);
    check("t1_side", {bk_tstrb, bk_tkeep, bk_user, bk_last}, {4'hF, 4'hF, 2'b01, 1'b1});
    step();
    check("t1_done", frame_done, 1);
    check("t1_cnt", beat_cnt, 1);
    check("t1_empty", bk_valid, 0);
    step();
    check("t1_done_clr", frame_done, 0);
    // backpressure fill and drain
    bk_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(i, 4'hF, i == 7);
      check($sformatf("t2_tready_%0d", i), tready, 1);
      step();
    end
    idle();
    check("t2_full", tready, 0);
    check("t2_head", bk_data, 0);
    check("t2_nordy_full", nordy, 1);
    bk_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_data_%0d", i), bk_data, i);
      step();
      if (i == 0) begin
        check("t2_tready_back", tready, 1);
        check("t2_nordy_clr", nordy, 0);
      end
    end
    check("t2_done", frame_done, 1);
    check("t2_cnt", beat_cnt, 8);
    check("t2_empty", bk_valid, 0);
    // stall detect
    bk_ready = 1'b0;
    drive(32'h33, 4'hF, 1'b1);
    step();
    idle();
    for (int i = 0; i < 4; i++) step();
    check("t3_nordy_4", nordy, 0);
    step();
    check("t3_nordy_5", nordy, 1);
    step();
    check("t3_nordy_hold", nordy, 1);
    bk_ready = 1'b1;
    step();
    bk_ready = 1'b0;
    check("t3_nordy_clr", nordy, 0);
    check("t3_cnt", beat_cnt, 1);
    step();
    // null beat dropped mid-frame
    bk_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(32'h40 + i, i == 1 ? 4'h0 : 4'hF, i == 3);
      step();
      if (i == 1) check("t4_null_drop", bk_valid, 0);
      else check($sformatf("t4_data_%0d", i), bk_data, 32'h40 + i);
    end
    idle();
    check("t4_last", bk_last, 1);
    step();
    check("t4_done", frame_done, 1);
    check("t4_cnt", beat_cnt, 3);
    // frames of 3 then 2 beats, streamed
    for (int i = 0; i < 5; i++) begin
      drive(i < 3 ? 32'h50 + i : 32'h60 + i - 3, 4'hF, i == 2 || i == 4);
      step();
      if (i == 3) begin
        check("t5_done_a", frame_done, 1);
        check("t5_cnt_a", beat_cnt, 3);
      end
      if (i == 4) check("t5_gap", frame_done, 0);
    end
    idle();
    step();
    check("t5_done_b", frame_done, 1);
    check("t5_cnt_b", beat_cnt, 2);
    // two 1-beat frames give adjacent pulses
    for (int i = 0; i < 2; i++) begin
      drive(32'h90 + i, 4'hF, 1'b1);
      step();
    end
    idle();
    check("t5_pulse_1", frame_done, 1);
    step();
    check("t5_pulse_2", frame_done, 1);
    check("t5_cnt_1", beat_cnt, 1);
    step();
    check("t5_pulse_end", frame_done, 0);
    // reset mid-frame
    bk_ready = 1'b0;
    drive(32'h70, 4'hF, 1'b0);
    step();
    drive(32'h71, 4'hF, 1'b0);
    step();
    idle();
    check("t6_buffered", bk_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_zero("t6_async");
    step();
    step();
    check_zero("t6_hold");
    rst_n = 1'b1;
    step();
    bk_ready = 1'b1;
    drive(32'h80, 4'hF, 1'b1);
    step();
    idle();
    check("t6_data", bk_data, 32'h80);
    step();
    check("t6_done", frame_done, 1);
    check("t6_cnt", beat_cnt, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
